// File: rtl/gain_ramp_pkg.sv
// Shared types, constants and arithmetic helpers for the audio gain path.
package abies_audio_pkg;

    localparam int GAIN_W = 8;

    typedef logic [GAIN_W-1:0] gain_t;

    localparam gain_t GAIN_UNITY = gain_t'(1 << (GAIN_W - 1));
    localparam gain_t GAIN_MAX   = '1;

    typedef enum logic {
        DEB_STABLE,
        DEB_COUNTING
    } deb_state_t;

    // Round half up while dropping gw-1 fraction bits, then clamp to a signed dw-bit range.
    function automatic logic signed [63:0] sat_round(
        input logic signed [63:0] prod,
        input int                 dw,
        input int                 gw
    );
        logic signed [63:0] rnd;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        rnd = (prod + (64'sd1 <<< (gw - 2))) >>> (gw - 1);
        hi  = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (dw - 1));
        if (rnd > hi) begin
            return hi;
        end else if (rnd < lo) begin
            return lo;
        end
        return rnd;
    endfunction

endpackage

// File: rtl/gain_ramp_if.sv
// Sample path between the sample source, the gain stage and the I2S transmitter.
interface gain_ramp_if #(
    parameter int DW = 24
);
    logic                 rd_en;
    logic                 ce;
    logic                 in_valid;
    logic signed [DW-1:0] in_sample;
    logic                 out_valid;
    logic signed [DW-1:0] out_sample;

    modport master (
        output rd_en,
        output in_valid,
        output in_sample,
        input  ce,
        input  out_valid,
        input  out_sample
    );

    modport slave (
        input  rd_en,
        input  in_valid,
        input  in_sample,
        output ce,
        output out_valid,
        output out_sample
    );

endinterface

// File: rtl/gain_ramp_btn_debounce.sv
// Two-flop synchroniser followed by a counting debouncer; emits the settled level and a one-cycle rise pulse.
module btn_debounce
    import abies_audio_pkg::*;
#(
    parameter int DEB_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          sync_btn;
    deb_state_t    state_q;
    deb_state_t    state_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          level_d;
    logic          rise_d;

    assign sync_btn = sync_q[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], btn};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DEB_STABLE;
            count_q <= '0;
            level   <= 1'b0;
            rise    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            level   <= level_d;
            rise    <= rise_d;
        end
    end

    // Any return to the settled level during counting throws the partial count away.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        level_d = level;
        rise_d  = 1'b0;
        case (state_q)
            DEB_STABLE: begin
                count_d = '0;
                if (sync_btn != level) begin
                    state_d = DEB_COUNTING;
                end
            end
            DEB_COUNTING: begin
                if (sync_btn == level) begin
                    state_d = DEB_STABLE;
                    count_d = '0;
                end else if (count_q == LAST) begin
                    state_d = DEB_STABLE;
                    count_d = '0;
                    level_d = sync_btn;
                    rise_d  = sync_btn;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            default: begin
                state_d = DEB_STABLE;
                count_d = '0;
            end
        endcase
    end

endmodule

// File: rtl/gain_ramp.sv
// Forwards sample requests upstream and scales returned samples by a button-controlled gain that ramps one LSB per sample.
module gain_ramp
    import abies_audio_pkg::*;
#(
    parameter int DW         = 24,
    parameter int GW         = GAIN_W,
    parameter int GAIN_RESET = 16,
    parameter int GAIN_STEP  = 16,
    parameter int DEB_CYCLES = 65536
) (
    input  logic        clk,
    input  logic        rst,
    gain_ramp_if.slave  bus,
    input  logic        btn_up,
    input  logic        btn_dn,
    input  logic        mute,
    output gain_t       gain
);

    localparam int    PW        = DW + GW + 1;
    localparam gain_t GAIN_INIT = gain_t'(GAIN_RESET);

    logic                 up_rise;
    logic                 dn_rise;
    gain_t                saved_target;
    gain_t                saved_next;
    gain_t                target;
    int                   stepped;
    logic signed [GW:0]   gain_s;
    logic signed [PW-1:0] prod_q;
    logic                 valid_q;

    assign bus.ce = bus.rd_en;
    assign gain_s = {1'b0, gain};

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb_up (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_up),
        .level (),
        .rise  (up_rise)
    );

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb_dn (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_dn),
        .level (),
        .rise  (dn_rise)
    );

    // Presses keep updating the saved target while muted so unmuting restores the latest choice.
    always_comb begin
        saved_next = saved_target;
        stepped    = 0;
        if (up_rise && !dn_rise) begin
            stepped    = int'(saved_target) + GAIN_STEP;
            saved_next = (stepped > int'(GAIN_MAX)) ? GAIN_MAX : gain_t'(stepped);
        end else if (dn_rise && !up_rise) begin
            stepped    = int'(saved_target) - GAIN_STEP;
            saved_next = (stepped < 0) ? '0 : gain_t'(stepped);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            saved_target <= GAIN_INIT;
            target       <= GAIN_INIT;
        end else begin
            saved_target <= saved_next;
            target       <= mute ? '0 : saved_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gain <= GAIN_INIT;
        end else if (bus.in_valid) begin
            if (gain < target) begin
                gain <= gain + 1'b1;
            end else if (gain > target) begin
                gain <= gain - 1'b1;
            end
        end
    end

    // The multiply sees the gain from before this sample's ramp step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_q         <= '0;
            valid_q        <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.out_sample <= '0;
        end else begin
            valid_q       <= bus.in_valid;
            bus.out_valid <= valid_q;
            if (bus.in_valid) begin
                prod_q <= PW'(bus.in_sample) * PW'(gain_s);
            end
            if (valid_q) begin
                bus.out_sample <= DW'(sat_round(64'(prod_q), DW, GW));
            end
        end
    end

endmodule

// File: tb/tb_gain_ramp.sv
// Directed bench for gain_ramp with a short debounce window.
module tb_gain_ramp;
    import abies_audio_pkg::*;

    localparam int DW = 24;

    logic  clk;
    logic  rst;
    logic  btn_up;
    logic  btn_dn;
    logic  mute;
    gain_t gain;
    int    vector_count;
    int    fail_count;

    gain_ramp_if #(.DW(DW)) bus ();

    gain_ramp #(
        .DW         (DW),
        .GW         (8),
        .GAIN_RESET (16),
        .GAIN_STEP  (16),
        .DEB_CYCLES (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .btn_up (btn_up),
        .btn_dn (btn_dn),
        .mute   (mute),
        .gain   (gain)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vector_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One sample through the pipe: gain after the ramp step, then the strobe two edges later.
    task automatic applyStimulus(input int sample, input int exp_sample, input int exp_gain, input string tag);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_sample = 24'(sample);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checkOutput({tag, "_gain"}, int'(gain), exp_gain);
        checkOutput({tag, "_vld_early"}, int'(bus.out_valid), 0);
        @(negedge clk);
        checkOutput({tag, "_vld"}, int'(bus.out_valid), 1);
        checkOutput({tag, "_out"}, int'(bus.out_sample), exp_sample);
        @(negedge clk);
        checkOutput({tag, "_vld_late"}, int'(bus.out_valid), 0);
    endtask

    task automatic press_button(input logic up, input logic dn, input int hold);
        @(negedge clk);
        btn_up = up;
        btn_dn = dn;
        repeat (hold) @(negedge clk);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic seen_valid;
        vector_count  = 0;
        fail_count    = 0;
        rst           = 1'b0;
        btn_up        = 1'b0;
        btn_dn        = 1'b0;
        mute          = 1'b0;
        bus.rd_en     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sample = '0;

        repeat (3) @(negedge clk);
        checkOutput("rst_vld", int'(bus.out_valid), 0);
        checkOutput("rst_out", int'(bus.out_sample), 0);
        checkOutput("rst_gain", int'(gain), 16);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_gain", int'(gain), 16);

        bus.rd_en = 1'b1;
        #1;
        checkOutput("ce_hi", int'(bus.ce), 1);
        bus.rd_en = 1'b0;
        #1;
        checkOutput("ce_lo", int'(bus.ce), 0);

        applyStimulus(1000, 125, 16, "first");

        // back-to-back samples come out at the same rate
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_sample = 24'(1000);
        @(negedge clk);
        bus.in_sample = 24'(2000);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checkOutput("b2b_vld0", int'(bus.out_valid), 1);
        checkOutput("b2b_out0", int'(bus.out_sample), 125);
        @(negedge clk);
        checkOutput("b2b_vld1", int'(bus.out_valid), 1);
        checkOutput("b2b_out1", int'(bus.out_sample), 250);
        @(negedge clk);
        checkOutput("b2b_vld2", int'(bus.out_valid), 0);

        press_button(1'b1, 1'b0, 5);
        applyStimulus(0, 0, 16, "glitch");
        press_button(1'b1, 1'b1, 20);
        applyStimulus(0, 0, 16, "both");

        press_button(1'b1, 1'b0, 20);
        for (int i = 1; i <= 16; i++) applyStimulus(0, 0, 16 + i, "ramp_up");
        applyStimulus(0, 0, 32, "ramp_hold");
        applyStimulus(1000, 250, 32, "gain32");

        @(negedge clk);
        mute = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 32; i++) applyStimulus(0, 0, 32 - i, "mute_ramp");
        applyStimulus(1000, 0, 0, "mute_out");
        press_button(1'b1, 1'b0, 20);
        applyStimulus(1000, 0, 0, "mute_press");
        @(negedge clk);
        mute = 1'b0;
        @(negedge clk);
        for (int i = 1; i <= 48; i++) applyStimulus(0, 0, i, "unmute_ramp");
        applyStimulus(0, 0, 48, "unmute_hold");

        repeat (5) press_button(1'b1, 1'b0, 20);
        for (int i = 49; i <= 128; i++) applyStimulus(0, 0, i, "to_unity");
        applyStimulus(-3, -3, int'(GAIN_UNITY), "round_unity");

        repeat (4) press_button(1'b0, 1'b1, 20);
        for (int i = 127; i >= 64; i--) applyStimulus(0, 0, i, "to_half");
        applyStimulus(-3, -1, 64, "round_half");

        repeat (20) press_button(1'b1, 1'b0, 20);
        for (int i = 65; i <= 255; i++) applyStimulus(0, 0, i, "to_max");
        applyStimulus(8388607, 8388607, 255, "sat_pos");
        applyStimulus(-8388608, -8388608, 255, "sat_neg");

        // reset lands while a sample sits between the two pipeline stages
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_sample = 24'(1000);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst          = 1'b0;
        #1;
        checkOutput("midrst_vld", int'(bus.out_valid), 0);
        checkOutput("midrst_out", int'(bus.out_sample), 0);
        @(negedge clk);
        rst        = 1'b1;
        seen_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen_valid = seen_valid | bus.out_valid;
        end
        checkOutput("midrst_no_vld", int'(seen_valid), 0);
        checkOutput("midrst_out_after", int'(bus.out_sample), 0);
        checkOutput("midrst_gain", int'(gain), 16);

        repeat (20) press_button(1'b0, 1'b1, 20);
        for (int i = 15; i >= 0; i--) applyStimulus(0, 0, i, "to_zero");
        applyStimulus(1000, 0, 0, "zero_hold");

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, fail_count);
        $finish;
    end

endmodule
